// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: fetch PC, imem request port and a DEPTH-entry
// {pc, instruction} prefetch queue drained by decode through valid/ready.
module fetch_queue_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic                     imem_req_o,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
    input  logic                     redirect_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [DATA_WIDTH-1:0]    instr_data_o,
    output logic [ADDR_WIDTH-1:0]    instr_pc_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LevelFull = LvlW'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic [ADDR_WIDTH-1:0] ent_pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];

    logic push, pop;
    logic unused_redirect_lsb;

    // Target is word-aligned; the low bits are dropped on purpose.
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Request is gated by rst_ni so it stays low for the whole reset window.
    assign imem_req_o    = rst_ni && !redirect_i && (level_q != LevelFull);
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (level_q != '0);
    assign level_o       = level_q;
    assign instr_data_o  = instr_valid_o ? ent_data_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? ent_pc_q[rd_ptr_q] : '0;

    assign push = imem_req_o;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_VECTOR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_pc_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
        end else if (push) begin
            ent_pc_q[wr_ptr_q]   <= fetch_pc_q;
            ent_data_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: imem returns addr ^ 0xA5A5A5A5,
// inputs change 1ns after each rising edge, outputs sampled 1ns later.
module tb_fetch_queue_unit;

    localparam logic [31:0] Rv  = 32'h0040_0000;
    localparam logic [31:0] Key = 32'hA5A5_A5A5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic [2:0]  level_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    assign imem_rdata_i = imem_addr_o ^ Key;

    fetch_queue_unit #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH       (4),
        .RESET_VECTOR(Rv)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_data_o (instr_data_o),
        .instr_pc_o   (instr_pc_o),
        .level_o      (level_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
        check_eq({tag, "_pc"}, instr_pc_o, pc);
        check_eq({tag, "_data"}, instr_data_o, pc ^ Key);
    endtask

    logic [31:0] exp_pc;

    initial begin
        rst_ni        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b1;

        // Reset state
        tick();
        tick();
        check_eq("rst_req", {31'b0, imem_req_o}, 32'd0);
        check_eq("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("rst_level", {29'b0, level_o}, 32'd0);
        check_eq("rst_data", instr_data_o, 32'd0);
        check_eq("rst_pc", instr_pc_o, 32'd0);
        check_eq("rst_addr", imem_addr_o, Rv);

        // Streaming with ready held high
        rst_ni = 1'b1;
        #1;
        check_eq("rel_req", {31'b0, imem_req_o}, 32'd1);
        check_eq("rel_valid", {31'b0, instr_valid_o}, 32'd0);
        tick();
        check_head("stream0", Rv);
        check_eq("stream0_addr", imem_addr_o, Rv + 32'd4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_head("stream", Rv + 32'(4 * k));
            check_eq("stream_addr", imem_addr_o, Rv + 32'(4 * (k + 1)));
            check_eq("stream_level", {29'b0, level_o}, 32'd1);
        end

        // Fill to full with ready low
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1000;
        instr_ready_i = 1'b0;
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("fill_level0", {29'b0, level_o}, 32'd0);
        check_eq("fill_addr0", imem_addr_o, 32'h0000_1000);
        repeat (4) tick();
        check_eq("full_level", {29'b0, level_o}, 32'd4);
        check_eq("full_req", {31'b0, imem_req_o}, 32'd0);
        check_eq("full_addr", imem_addr_o, 32'h0000_1010);
        tick();
        check_eq("full_hold_addr", imem_addr_o, 32'h0000_1010);
        check_eq("full_hold_level", {29'b0, level_o}, 32'd4);
        instr_ready_i = 1'b1;
        #1;
        check_head("full_head", 32'h0000_1000);
        check_eq("full_pop_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        instr_ready_i = 1'b0;
        #1;
        check_eq("after_pop_level", {29'b0, level_o}, 32'd3);
        check_head("after_pop_head", 32'h0000_1004);
        check_eq("resume_req", {31'b0, imem_req_o}, 32'd1);
        check_eq("resume_addr", imem_addr_o, 32'h0000_1010);

        // Redirect at level 3 with a simultaneous handshake
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0123;
        instr_ready_i = 1'b1;
        #1;
        check_eq("redir_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("redir_level", {29'b0, level_o}, 32'd0);
        check_eq("redir_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("redir_addr", imem_addr_o, 32'h0040_0120);
        check_eq("redir_pc0", instr_pc_o, 32'd0);
        tick();
        check_head("redir_head", 32'h0040_0120);

        // Fetch PC wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("wrap_addr", imem_addr_o, 32'hFFFF_FFF8);
        tick();
        check_head("wrap0", 32'hFFFF_FFF8);
        tick();
        check_head("wrap1", 32'hFFFF_FFFC);
        tick();
        check_head("wrap2", 32'h0000_0000);
        check_eq("wrap_addr2", imem_addr_o, 32'h0000_0004);

        // Back-to-back redirects: last target wins
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick();
        redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        #1;
        check_eq("b2b_addr", imem_addr_o, 32'h0000_0200);
        check_eq("b2b_level", {29'b0, level_o}, 32'd0);
        tick();
        check_head("b2b_head", 32'h0000_0200);

        // Asynchronous reset mid-cycle at level 2
        instr_ready_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_3000;
        tick();
        redirect_i = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_level", {29'b0, level_o}, 32'd2);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", {31'b0, instr_valid_o}, 32'd0);
        check_eq("arst_level", {29'b0, level_o}, 32'd0);
        check_eq("arst_req", {31'b0, imem_req_o}, 32'd0);
        check_eq("arst_addr", imem_addr_o, Rv);
        check_eq("arst_pc", instr_pc_o, 32'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        check_head("arst_restart", Rv);

        // Random ready, no redirects: contiguous, bounded, lossless
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_8000;
        tick();
        redirect_i = 1'b0;
        exp_pc = 32'h0000_8000;
        for (int c = 0; c < 1000; c++) begin
            instr_ready_i = 1'($urandom_range(0, 1));
            #1;
            check_eq("rand_level_bound", {31'b0, (level_o <= 3'd4)}, 32'd1);
            if (instr_valid_o && instr_ready_i) begin
                check_eq("rand_pc", instr_pc_o, exp_pc);
                check_eq("rand_data", instr_data_o, exp_pc ^ Key);
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        check_eq("rand_progress", {31'b0, (exp_pc > 32'h0000_8400)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
